// File: rtl/mips_multicycle_fsm.sv
// Multi-cycle MIPS control sequencer: Moore FSM with Mealy-gated memory handshake and timeout.
// Define MIPS_FSM_PERF_EN to add the cycle_cnt / instret_cnt performance counters.
module mips_multicycle_fsm #(
   parameter int unsigned MEM_TIMEOUT = 15,
   parameter int unsigned WAIT_W      = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [5:0] opcode,
   input  logic       halt,
   input  logic       mem_ready,
   output logic       mem_req,
   output logic       mem_we,
   output logic       i_or_d,
   output logic       ir_write,
   output logic       pc_write,
   output logic       pc_write_cond,
   output logic [1:0] pc_source,
   output logic       alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [1:0] alu_op,
   output logic       reg_dst,
   output logic       mem_to_reg,
   output logic       reg_write,
   output logic       illegal,
   output logic       mem_err,
   output logic [3:0] state
`ifdef MIPS_FSM_PERF_EN
   ,
   output logic [31:0] cycle_cnt,
   output logic [31:0] instret_cnt
`endif
);

   typedef enum logic [3:0] {
      StIdle    = 4'd0,
      StFetch   = 4'd1,
      StDecode  = 4'd2,
      StMemAddr = 4'd3,
      StMemRd   = 4'd4,
      StMemWb   = 4'd5,
      StMemWr   = 4'd6,
      StExec    = 4'd7,
      StAluWb   = 4'd8,
      StBranch  = 4'd9,
      StJump    = 4'd10,
      StImmEx   = 4'd11,
      StImmWb   = 4'd12
   } state_e;

   localparam logic [WAIT_W-1:0] WaitLimit = WAIT_W'(MEM_TIMEOUT - 1);

   state_e            state_q, state_d;
   logic [WAIT_W-1:0] wait_q, wait_d;
   logic              done;
   logic              at_limit;
   state_e            after_done;

   assign at_limit   = (wait_q == WaitLimit);
   assign after_done = halt ? StIdle : StFetch;
   assign state      = rst ? 4'd0 : state_q;

   always_ff @(posedge clk) begin
      state_q <= state_d;
      wait_q  <= wait_d;
   end

   always_comb begin
      state_d       = state_q;
      done          = 1'b0;
      mem_req       = 1'b0;
      mem_we        = 1'b0;
      i_or_d        = 1'b0;
      ir_write      = 1'b0;
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      pc_source     = 2'd0;
      alu_src_a     = 1'b0;
      alu_src_b     = 2'd0;
      alu_op        = 2'd0;
      reg_dst       = 1'b0;
      mem_to_reg    = 1'b0;
      reg_write     = 1'b0;
      illegal       = 1'b0;
      mem_err       = 1'b0;

      case (state_q)
         StIdle: begin
            if (!halt) state_d = StFetch;
         end
         StFetch: begin
            mem_req   = 1'b1;
            alu_src_b = 2'd1;
            // mem_ready in the timeout cycle still counts as a completed access
            if (mem_ready) begin
               ir_write = 1'b1;
               pc_write = 1'b1;
               state_d  = StDecode;
            end else if (at_limit) begin
               mem_err = 1'b1;
               state_d = StIdle;
            end
         end
         StDecode: begin
            alu_src_b = 2'd3;
            case (opcode)
               6'b000000:           state_d = StExec;
               6'b100011, 6'b101011: state_d = StMemAddr;
               6'b000100:           state_d = StBranch;
               6'b000010:           state_d = StJump;
               6'b001000:           state_d = StImmEx;
               default: begin
                  illegal = 1'b1;
                  state_d = after_done;
               end
            endcase
         end
         StMemAddr: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'd2;
            state_d   = opcode[3] ? StMemWr : StMemRd;
         end
         StMemRd: begin
            mem_req = 1'b1;
            i_or_d  = 1'b1;
            if (mem_ready) begin
               state_d = StMemWb;
            end else if (at_limit) begin
               mem_err = 1'b1;
               state_d = StIdle;
            end
         end
         StMemWb: begin
            reg_write  = 1'b1;
            mem_to_reg = 1'b1;
            done       = 1'b1;
            state_d    = after_done;
         end
         StMemWr: begin
            mem_req = 1'b1;
            mem_we  = 1'b1;
            i_or_d  = 1'b1;
            if (mem_ready) begin
               done    = 1'b1;
               state_d = after_done;
            end else if (at_limit) begin
               mem_err = 1'b1;
               state_d = StIdle;
            end
         end
         StExec: begin
            alu_src_a = 1'b1;
            alu_op    = 2'd2;
            state_d   = StAluWb;
         end
         StAluWb: begin
            reg_write = 1'b1;
            reg_dst   = 1'b1;
            done      = 1'b1;
            state_d   = after_done;
         end
         StBranch: begin
            alu_src_a     = 1'b1;
            alu_op        = 2'd1;
            pc_write_cond = 1'b1;
            pc_source     = 2'd1;
            done          = 1'b1;
            state_d       = after_done;
         end
         StJump: begin
            pc_write  = 1'b1;
            pc_source = 2'd2;
            done      = 1'b1;
            state_d   = after_done;
         end
         StImmEx: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'd2;
            state_d   = StImmWb;
         end
         StImmWb: begin
            reg_write = 1'b1;
            done      = 1'b1;
            state_d   = after_done;
         end
         default: state_d = StIdle;
      endcase

      if (rst) begin
         state_d       = StIdle;
         done          = 1'b0;
         mem_req       = 1'b0;
         mem_we        = 1'b0;
         i_or_d        = 1'b0;
         ir_write      = 1'b0;
         pc_write      = 1'b0;
         pc_write_cond = 1'b0;
         pc_source     = 2'd0;
         alu_src_a     = 1'b0;
         alu_src_b     = 2'd0;
         alu_op        = 2'd0;
         reg_dst       = 1'b0;
         mem_to_reg    = 1'b0;
         reg_write     = 1'b0;
         illegal       = 1'b0;
         mem_err       = 1'b0;
      end
   end

   // Counter restarts on every state change so each memory state gets a fresh budget
   always_comb begin
      wait_d = wait_q;
      if (rst || (state_d != state_q)) begin
         wait_d = '0;
      end else if (mem_req && !mem_ready) begin
         wait_d = wait_q + 1'b1;
      end
   end

`ifdef MIPS_FSM_PERF_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         cycle_cnt   <= 32'd0;
         instret_cnt <= 32'd0;
      end else begin
         if (state_q != StIdle) cycle_cnt <= cycle_cnt + 32'd1;
         if (done) instret_cnt <= instret_cnt + 32'd1;
      end
   end
`endif

endmodule
